// File: rtl/mem_port_arbiter.sv
// Arbitrates one backend memory port between instruction fetch and load/store.
// Data wins by default; a bounded data streak guarantees that a waiting fetch is eventually granted.
module mem_port_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    input  logic [7:0]  mem_be,
    output logic [63:0] mem_rdata,
    output logic        mem_valid,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_be,
    input  logic        bus_ack,
    input  logic [63:0] bus_rdata
);

    // state        | meaning
    // S_IDLE       | no backend transaction, grant decided this cycle
    // S_FETCH      | fetch outstanding on the bus
    // S_DATA       | load/store outstanding on the bus
    // S_FETCH_DROP | cancelled fetch outstanding, result discarded on ack
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_FETCH      = 2'd1,
        S_DATA       = 2'd2,
        S_FETCH_DROP = 2'd3
    } state_t;

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    state_t        state, state_next;
    logic [SW-1:0] streak, streak_next;
    logic          grant_data, grant_fetch;
    logic          done_fetch, done_data;
    logic          if_wait, mem_elig;
    logic          fetch_hi;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[1:0], mem_addr[2:0]};

    // A requester whose completion pulse is showing is still holding its old request.
    assign if_wait  = if_req && !if_valid;
    assign mem_elig = mem_req && !mem_valid;

    assign if_stall  = if_req && !if_valid;
    assign mem_stall = mem_req && !mem_valid;

    always_comb begin
        state_next  = state;
        streak_next = streak;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        done_fetch  = 1'b0;
        done_data   = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_elig && (streak < STREAK_MAX || !if_wait)) begin
                    grant_data = 1'b1;
                    state_next = S_DATA;
                    // with a fetch waiting, streak < STREAK_MAX here, so this saturates naturally
                    streak_next = if_wait ? streak + 1'b1 : '0;
                end else if (if_wait && !if_flush) begin
                    grant_fetch = 1'b1;
                    state_next  = S_FETCH;
                    streak_next = '0;
                end
            end
            S_FETCH: begin
                if (bus_ack) begin
                    state_next = S_IDLE;
                    done_fetch = !if_flush;
                end else if (if_flush) begin
                    state_next = S_FETCH_DROP;
                end
            end
            S_DATA: begin
                if (bus_ack) begin
                    state_next = S_IDLE;
                    done_data  = 1'b1;
                end
            end
            S_FETCH_DROP: begin
                if (bus_ack) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            streak <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            fetch_hi  <= 1'b0;
            if_inst   <= '0;
            if_valid  <= 1'b0;
            mem_rdata <= '0;
            mem_valid <= 1'b0;
        end else begin
            if (grant_data) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_we;
                bus_addr  <= {mem_addr[63:3], 3'b000};
                bus_wdata <= mem_wdata;
                bus_be    <= mem_be;
            end else if (grant_fetch) begin
                bus_req   <= 1'b1;
                bus_we    <= 1'b0;
                bus_addr  <= {if_addr[63:3], 3'b000};
                bus_wdata <= '0;
                bus_be    <= 8'h00;
                fetch_hi  <= if_addr[2];
            end else if (state != S_IDLE && bus_ack) begin
                bus_req <= 1'b0;
            end
            if_valid  <= done_fetch;
            mem_valid <= done_data;
            if (done_fetch) if_inst <= fetch_hi ? bus_rdata[63:32] : bus_rdata[31:0];
            if (done_data) mem_rdata <= bus_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled on the falling edge.
// Expected values are hand-computed per scenario.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, if_flush;
    logic [63:0] if_addr;
    logic [31:0] if_inst;
    logic        if_valid, if_stall;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_be;
    logic [63:0] mem_rdata;
    logic        mem_valid, mem_stall;
    logic        bus_req, bus_we;
    logic [63:0] bus_addr, bus_wdata;
    logic [7:0]  bus_be;
    logic        bus_ack;
    logic [63:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] ST_IDLE = 64'd0;
    localparam logic [63:0] ST_FETCH = 64'd1;
    localparam logic [63:0] ST_DATA = 64'd2;
    localparam logic [63:0] ST_DROP = 64'd3;

    mem_port_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_inst(if_inst), .if_valid(if_valid), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_stall(mem_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    always @(negedge clock) chk("one_valid", 64'(if_valid && mem_valid), 64'd0);

    initial begin
        reset = 1'b0;
        if_req = 0; if_flush = 0; if_addr = '0;
        mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
        bus_ack = 0; bus_rdata = '0;

        // reset state
        cyc();
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_bus_addr", bus_addr, 64'd0);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_if_inst", 64'(if_inst), 64'd0);
        chk("rst_state", 64'(dut.state), ST_IDLE);
        chk("rst_streak", 64'(dut.streak), 64'd0);
        reset = 1'b1;
        cyc();

        // single fetch from the upper word
        if_req = 1; if_addr = 64'h1004;
        cyc();
        chk("t1_bus_req", 64'(bus_req), 64'd1);
        chk("t1_bus_addr", bus_addr, 64'h1000);
        chk("t1_bus_be", 64'(bus_be), 64'd0);
        chk("t1_bus_we", 64'(bus_we), 64'd0);
        chk("t1_if_stall", 64'(if_stall), 64'd1);
        bus_ack = 1; bus_rdata = 64'hAAAAAAAA_BBBBBBBB;
        cyc();
        chk("t1_if_valid", 64'(if_valid), 64'd1);
        chk("t1_if_inst", 64'(if_inst), 64'hAAAAAAAA);
        chk("t1_if_stall_off", 64'(if_stall), 64'd0);
        chk("t1_bus_req_off", 64'(bus_req), 64'd0);
        if_req = 0; bus_ack = 0;
        cyc();
        chk("t1_if_valid_1cyc", 64'(if_valid), 64'd0);

        // simultaneous store and fetch: data first
        mem_req = 1; mem_we = 1; mem_addr = 64'h200C; mem_wdata = 64'h11223344_55667788; mem_be = 8'h0F;
        if_req = 1; if_addr = 64'h3000;
        cyc();
        chk("t2_state", 64'(dut.state), ST_DATA);
        chk("t2_bus_we", 64'(bus_we), 64'd1);
        chk("t2_bus_be", 64'(bus_be), 64'h0F);
        chk("t2_bus_addr", bus_addr, 64'h2008);
        chk("t2_bus_wdata", bus_wdata, 64'h11223344_55667788);
        chk("t2_mem_stall", 64'(mem_stall), 64'd1);
        bus_ack = 1; bus_rdata = 64'h0;
        cyc();
        chk("t2_mem_valid", 64'(mem_valid), 64'd1);
        chk("t2_mem_stall_off", 64'(mem_stall), 64'd0);
        chk("t2_if_valid", 64'(if_valid), 64'd0);
        mem_req = 0; mem_we = 0; bus_ack = 0;
        cyc();
        chk("t2_fetch_state", 64'(dut.state), ST_FETCH);
        chk("t2_fetch_addr", bus_addr, 64'h3000);
        chk("t2_fetch_we", 64'(bus_we), 64'd0);
        chk("t2_streak", 64'(dut.streak), 64'd0);
        bus_ack = 1; bus_rdata = 64'h01234567_89ABCDEF;
        cyc();
        chk("t2_if_inst", 64'(if_inst), 64'h89ABCDEF);
        if_req = 0; bus_ack = 0;
        cyc();

        // fairness: fetch held off by a redirect while loads stream
        if_req = 1; if_flush = 1; if_addr = 64'h4000;
        mem_req = 1; mem_we = 0; mem_addr = 64'h5000; mem_be = 8'hFF; mem_wdata = '0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("t3_state_%0d", i), 64'(dut.state), ST_DATA);
            chk($sformatf("t3_streak_%0d", i), 64'(dut.streak), 64'(i));
            bus_ack = 1; bus_rdata = 64'(i);
            cyc();
            chk($sformatf("t3_mem_valid_%0d", i), 64'(mem_valid), 64'd1);
            chk($sformatf("t3_mem_rdata_%0d", i), mem_rdata, 64'(i));
            bus_ack = 0;
            cyc();
            chk($sformatf("t3_inelig_%0d", i), 64'(bus_req), 64'd0);
        end
        cyc();
        chk("t3_limit_hold", 64'(bus_req), 64'd0);
        chk("t3_streak_sat", 64'(dut.streak), 64'd4);
        if_flush = 0;
        cyc();
        chk("t3_fetch_state", 64'(dut.state), ST_FETCH);
        chk("t3_fetch_addr", bus_addr, 64'h4000);
        chk("t3_streak_clr", 64'(dut.streak), 64'd0);
        bus_ack = 1; bus_rdata = 64'h00000000_DEADBEEF;
        cyc();
        chk("t3_if_valid", 64'(if_valid), 64'd1);
        chk("t3_if_inst", 64'(if_inst), 64'hDEADBEEF);
        if_req = 0; bus_ack = 0;
        cyc();
        chk("t3_data_resume", 64'(dut.state), ST_DATA);
        chk("t3_streak_zero", 64'(dut.streak), 64'd0);
        bus_ack = 1; bus_rdata = 64'h55;
        cyc();
        chk("t3_resume_valid", 64'(mem_valid), 64'd1);
        mem_req = 0; bus_ack = 0;
        cyc();

        // flush during an outstanding fetch
        if_req = 1; if_addr = 64'h6000;
        cyc();
        chk("t4_state_fetch", 64'(dut.state), ST_FETCH);
        cyc();
        if_flush = 1; if_addr = 64'h7000;
        cyc();
        chk("t4_state_drop", 64'(dut.state), ST_DROP);
        chk("t4_bus_req_hold", 64'(bus_req), 64'd1);
        if_flush = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("t4_drop_addr_%0d", k), bus_addr, 64'h6000);
            chk($sformatf("t4_drop_novalid_%0d", k), 64'(if_valid), 64'd0);
        end
        bus_ack = 1; bus_rdata = 64'hFFFFFFFF_FFFFFFFF;
        cyc();
        chk("t4_drop_done_valid", 64'(if_valid), 64'd0);
        chk("t4_drop_done_state", 64'(dut.state), ST_IDLE);
        chk("t4_drop_done_req", 64'(bus_req), 64'd0);
        bus_ack = 0;
        cyc();
        chk("t4_new_fetch_state", 64'(dut.state), ST_FETCH);
        chk("t4_new_fetch_addr", bus_addr, 64'h7000);
        if_flush = 1; bus_ack = 1; bus_rdata = 64'h12121212_34343434;
        cyc();
        chk("t4_coinc_valid", 64'(if_valid), 64'd0);
        chk("t4_coinc_state", 64'(dut.state), ST_IDLE);
        if_flush = 0; bus_ack = 0; if_addr = 64'h8004;
        cyc();
        chk("t4_refetch_addr", bus_addr, 64'h8000);
        bus_ack = 1; bus_rdata = 64'hCAFEF00D_12345678;
        cyc();
        chk("t4_refetch_valid", 64'(if_valid), 64'd1);
        chk("t4_refetch_inst", 64'(if_inst), 64'hCAFEF00D);
        if_req = 0; bus_ack = 0;
        cyc();

        // reset in the middle of a data transaction
        mem_req = 1; mem_we = 1; mem_addr = 64'h9000; mem_wdata = 64'h0BADC0DE_0BADC0DE; mem_be = 8'hFF;
        cyc();
        chk("t5_pre_req", 64'(bus_req), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("t5_bus_req", 64'(bus_req), 64'd0);
        chk("t5_bus_we", 64'(bus_we), 64'd0);
        chk("t5_bus_addr", bus_addr, 64'd0);
        chk("t5_bus_wdata", bus_wdata, 64'd0);
        chk("t5_bus_be", 64'(bus_be), 64'd0);
        chk("t5_mem_valid", 64'(mem_valid), 64'd0);
        chk("t5_state", 64'(dut.state), ST_IDLE);
        mem_req = 0; mem_we = 0;
        cyc();
        cyc();
        reset = 1'b1;
        mem_req = 1; mem_addr = 64'hA010; mem_wdata = '0;
        cyc();
        chk("t5_fresh_state", 64'(dut.state), ST_DATA);
        chk("t5_fresh_addr", bus_addr, 64'hA010);
        bus_ack = 1; bus_rdata = 64'hFEEDFACE_00C0FFEE;
        cyc();
        chk("t5_fresh_valid", 64'(mem_valid), 64'd1);
        chk("t5_fresh_rdata", mem_rdata, 64'hFEEDFACE_00C0FFEE);
        mem_req = 0; bus_ack = 0;
        cyc();

        // back-to-back loads, ack latency 0..7
        mem_req = 1; mem_we = 0; mem_be = 8'hF0;
        mem_addr = 64'hB000; mem_wdata = 64'h5A5A0000;
        for (int l = 0; l < 8; l++) begin
            logic [63:0] ea, ew, rd;
            ea = 64'hB000 + 64'(l) * 64'd8;
            ew = 64'h5A5A0000 + 64'(l);
            rd = 64'h1111111111111111 * 64'(l + 1);
            cyc();
            chk($sformatf("t6_state_%0d", l), 64'(dut.state), ST_DATA);
            chk($sformatf("t6_addr_%0d", l), bus_addr, ea);
            for (int k = 0; k < l; k++) begin
                cyc();
                chk($sformatf("t6_hold_addr_%0d_%0d", l, k), bus_addr, ea);
                chk($sformatf("t6_hold_wdata_%0d_%0d", l, k), bus_wdata, ew);
                chk($sformatf("t6_hold_be_%0d_%0d", l, k), 64'(bus_be), 64'hF0);
            end
            bus_ack = 1; bus_rdata = rd;
            cyc();
            chk($sformatf("t6_valid_%0d", l), 64'(mem_valid), 64'd1);
            chk($sformatf("t6_rdata_%0d", l), mem_rdata, rd);
            bus_ack = 0;
            if (l < 7) begin
                mem_addr = ea + 64'd8;
                mem_wdata = ew + 64'd1;
                cyc();
                chk($sformatf("t6_inelig_%0d", l), 64'(bus_req), 64'd0);
            end else begin
                mem_req = 0;
            end
        end
        cyc();
        chk("t6_final_idle", 64'(dut.state), ST_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one backend memory port between instruction fetch (IF stage) and load/store (MEM stage) of the 64-bit pipeline.
- Registers and holds each backend transaction until the variable-latency bus acknowledges it, then returns the result to the owning stage.
- Drives per-stage stall signals and discards fetches cancelled by branch, jump or exception redirect.
- Data has priority over fetch, with a bounded-streak fairness rule so fetch cannot starve.

Parameters:
- MAX_DATA_STREAK, 4: maximum consecutive data grants while a fetch is waiting; after this many, the next grant goes to fetch.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_valid.
- if_addr  in  64  fetch address, 4-byte aligned.
- if_flush  in  1  redirect (J/JR/branch taken/takenHandler); cancels the current fetch.
- if_inst  out  32  fetched instruction; valid when if_valid.
- if_valid  out  1  one-cycle pulse, fetch complete.
- if_stall  out  1  if_req && !if_valid.
- mem_req  in  1  data request; held with the other mem_* inputs stable until mem_valid.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  64  data address.
- mem_wdata  in  64  store data.
- mem_be  in  8  byte enables (word_we/byte_we already decoded).
- mem_rdata  out  64  load data; valid when mem_valid.
- mem_valid  out  1  one-cycle pulse, data access complete (loads and stores).
- mem_stall  out  1  mem_req && !mem_valid.
- bus_req  out  1  backend request, registered.
- bus_we  out  1  backend write, registered.
- bus_addr  out  64  backend address, 8-byte aligned (low 3 bits forced to 0), registered.
- bus_wdata  out  64  registered.
- bus_be  out  8  registered; 8'h00 for fetches.
- bus_ack  in  1  backend completion; sampled only while bus_req = 1.
- bus_rdata  in  64  valid in the bus_ack cycle.

Behaviour:
- States: IDLE, FETCH, DATA, FETCH_DROP.
- Reset (reset = 0, asynchronous): state IDLE; all outputs 0 (bus_*, if_inst, if_valid, mem_rdata, mem_valid); streak counter 0.
- Reset asserted mid-transaction: bus_req drops immediately and the transaction is abandoned. The backend must accept a request withdrawn without ack.

Grant in IDLE (cycle N, decided on requests sampled at N):
- mem_req && (streak < MAX_DATA_STREAK || !if_req) -> DATA. streak increments if if_req is also high; otherwise streak clears to 0.
- else if_req && !if_flush -> FETCH; streak clears to 0.
- else stay in IDLE.
- On grant: bus_req = 1 from cycle N+1, with bus_we, bus_addr, bus_wdata and bus_be latched from the granted requester. These are held constant until ack.
- A requester whose valid pulse is in the current cycle is not eligible for a grant in that cycle.

Completion:
- bus_ack at cycle M while in FETCH or DATA:
  - bus_req = 0 at M+1; state IDLE at M+1.
  - The matching valid pulse and registered data appear at M+1.
  - Next grant is possible at M+1, so the next bus_req rises at M+2.
  - Minimum turnaround: 2 cycles from grant to valid when ack is given in the first bus_req cycle.
- if_inst = latched if_addr[2] ? bus_rdata[63:32] : bus_rdata[31:0] (little-endian).
- mem_rdata = bus_rdata in full; the MEM stage does byte/sign extraction. For stores, mem_rdata is don't-care and mem_valid still pulses.

Flush:
- if_flush in FETCH, or in the same cycle as bus_ack in FETCH -> no if_valid is produced for that fetch.
- If the ack has not arrived, the state moves to FETCH_DROP. bus_req stays high until ack, then the state returns to IDLE silently.
- if_flush in DATA or IDLE has no effect on the data path.
- A fetch for the new PC is granted only after the drop completes.

Fairness:
- streak saturates at MAX_DATA_STREAK.
- Once the limit is reached with if_req high, fetch is granted even if mem_req is high.
- valid outputs are exactly one cycle wide. At most one of if_valid or mem_valid is high in any cycle.

Test Plan:
- Single fetch, if_addr = 0x1004, ack on first bus_req cycle with bus_rdata = 0xAAAAAAAA_BBBBBBBB -> bus_addr = 0x1000, bus_be = 0; if_inst = 0xAAAAAAAA, if_valid high exactly 1 cycle; if_stall high until then.
- mem_req and if_req raised in the same cycle, mem store with be = 8'h0F -> DATA granted first with bus_we = 1, bus_be = 0x0F; fetch issued at the cycle after mem_valid; mem_stall deasserts with mem_valid.
- Continuous mem_req with if_req pending, MAX_DATA_STREAK = 4 -> data grants 1–4, then a fetch grant, then data resumes; streak observed resetting to 0.
- if_flush two cycles after FETCH grant, ack 5 cycles later -> state FETCH_DROP, no if_valid; a new fetch is granted after the ack. Repeat with if_flush coinciding with bus_ack -> no if_valid.
- reset pulled low while bus_req = 1 in DATA -> bus_req, mem_valid and all outputs 0 at once; after release, state IDLE and a fresh request completes normally.
- Back-to-back loads, ack latency varied 0–7 cycles -> mem_rdata matches bus_rdata each time; bus_addr, bus_wdata and bus_be stable while bus_req is high and not acked.
